// File: rtl/dvi_stream_timing.sv
// dvi_stream_timing: video timing generator and pixel-stream aligner for the DVI pin stage.
// Generates DE/HSYNC/VSYNC on the dot clock. It pulls 24-bit RGB beats from a valid/ready
// stream during the active area only, and uses the SOF marker to lock that stream to the
// frame origin. Fill pixels are output while seeking and on underflow.
//
// Ports:
//   clk_dot        dot clock
//   reset_n        asynchronous active-low reset
//   enable         runs the timing when high; low returns to IDLE on the next clock
//   pix_valid/pix_sof/pix_rgb/pix_ready   input pixel stream (valid/ready)
//   vid_de/vid_hs/vid_vs/vid_rgb          registered video outputs to the pin stage
//   frame_start    one-cycle pulse with output pixel (0,0)
//   sof_err        one-cycle pulse on loss of frame alignment
//   underflow_cnt  saturating count of underflowed active pixels
//
// Optional feature macro: DVI_STREAM_TIMING_TEST_PATTERN_EN
//   defined   : fill pixels are 8 vertical colour bars
//   undefined : fill pixels are black
module dvi_stream_timing #(
  parameter int unsigned H_ACTIVE = 800,
  parameter int unsigned H_FP     = 40,
  parameter int unsigned H_SYNC   = 128,
  parameter int unsigned H_BP     = 88,
  parameter int unsigned V_ACTIVE = 600,
  parameter int unsigned V_FP     = 1,
  parameter int unsigned V_SYNC   = 4,
  parameter int unsigned V_BP     = 23,
  parameter bit          HS_POL   = 1'b1,
  parameter bit          VS_POL   = 1'b1
) (
  input  logic        clk_dot,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        pix_valid,
  input  logic        pix_sof,
  input  logic [23:0] pix_rgb,
  output logic        pix_ready,
  output logic        vid_de,
  output logic        vid_hs,
  output logic        vid_vs,
  output logic [23:0] vid_rgb,
  output logic        frame_start,
  output logic        sof_err,
  output logic [15:0] underflow_cnt
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW      = $clog2(H_TOTAL + 1);
  localparam int unsigned VW      = $clog2(V_TOTAL + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEEK   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t        state;
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          h_last;
  logic          v_last;
  logic          active;
  logic          hs_on;
  logic          vs_on;
  logic          origin;
  logic          eof;
  logic          sof_head;
  logic          take;
  logic [23:0]   fill_rgb;

  // Position decode and stream handshake from registered state/counters.
  always_comb begin
    h_last    = (h_cnt == HW'(H_TOTAL - 1));
    v_last    = (v_cnt == VW'(V_TOTAL - 1));
    active    = (h_cnt < HW'(H_ACTIVE)) && (v_cnt < VW'(V_ACTIVE));
    hs_on     = (h_cnt >= HW'(H_ACTIVE + H_FP)) && (h_cnt < HW'(H_ACTIVE + H_FP + H_SYNC));
    vs_on     = (v_cnt >= VW'(V_ACTIVE + V_FP)) && (v_cnt < VW'(V_ACTIVE + V_FP + V_SYNC));
    origin    = (h_cnt == '0) && (v_cnt == '0);
    eof       = h_last && v_last;
    sof_head  = pix_valid && pix_sof;
    pix_ready = 1'b0;
    case (state)
      // Drain everything up to the SOF beat, then hold it for the origin.
      SEEK:    pix_ready = !sof_head;
      // An SOF beat is only taken at the origin.
      LOCKED:  pix_ready = active && !(sof_head && !origin);
      default: pix_ready = 1'b0;
    endcase
    take = pix_valid && pix_ready;
  end

`ifdef DVI_STREAM_TIMING_TEST_PATTERN_EN
  localparam int unsigned BAR_W = ((H_ACTIVE / 8) > 0) ? (H_ACTIVE / 8) : 1;
  localparam int unsigned BW    = $clog2(BAR_W + 1);

  logic [2:0]    bar_idx;
  logic [BW-1:0] bar_pos;

  // Bar index tracks h_cnt without a divider; the last bar absorbs leftover pixels.
  always_ff @(posedge clk_dot or negedge reset_n) begin
    if (!reset_n) begin
      bar_idx <= '0;
      bar_pos <= '0;
    end else if (!enable || (state == IDLE) || h_last) begin
      bar_idx <= '0;
      bar_pos <= '0;
    end else if (bar_pos == BW'(BAR_W - 1)) begin
      bar_pos <= '0;
      if (bar_idx != 3'd7) bar_idx <= bar_idx + 3'd1;
    end else begin
      bar_pos <= bar_pos + BW'(1);
    end
  end

  // Colour bar lookup.
  always_comb begin
    fill_rgb = 24'h000000;
    case (bar_idx)
      3'd0:    fill_rgb = 24'hFFFFFF;
      3'd1:    fill_rgb = 24'hFFFF00;
      3'd2:    fill_rgb = 24'h00FFFF;
      3'd3:    fill_rgb = 24'h00FF00;
      3'd4:    fill_rgb = 24'hFF00FF;
      3'd5:    fill_rgb = 24'hFF0000;
      3'd6:    fill_rgb = 24'h0000FF;
      default: fill_rgb = 24'h000000;
    endcase
  end
`else
  assign fill_rgb = 24'h000000;
`endif

  // State, counters and registered video outputs.
  always_ff @(posedge clk_dot or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      h_cnt         <= '0;
      v_cnt         <= '0;
      vid_de        <= 1'b0;
      vid_hs        <= !HS_POL;
      vid_vs        <= !VS_POL;
      vid_rgb       <= '0;
      frame_start   <= 1'b0;
      sof_err       <= 1'b0;
      underflow_cnt <= '0;
    end else begin
      // Idle levels unless the timing runs this cycle.
      vid_de      <= 1'b0;
      vid_hs      <= !HS_POL;
      vid_vs      <= !VS_POL;
      vid_rgb     <= '0;
      frame_start <= 1'b0;
      sof_err     <= 1'b0;
      if (!enable) begin
        state <= IDLE;
        h_cnt <= '0;
        v_cnt <= '0;
      end else if (state == IDLE) begin
        state <= SEEK;
      end else begin
        h_cnt <= h_last ? '0 : h_cnt + HW'(1);
        if (h_last) v_cnt <= v_last ? '0 : v_cnt + VW'(1);
        vid_de      <= active;
        vid_hs      <= hs_on ? HS_POL : !HS_POL;
        vid_vs      <= vs_on ? VS_POL : !VS_POL;
        frame_start <= origin;
        if (active) vid_rgb <= fill_rgb;
        if (state == SEEK) begin
          if (eof && sof_head) state <= LOCKED;
        end else if (active) begin
          if (take) begin
            vid_rgb <= pix_rgb;
            // A non-SOF beat at the origin means the stream slipped.
            if (origin && !pix_sof) begin
              sof_err <= 1'b1;
              state   <= SEEK;
            end
          end else if (pix_valid) begin
            // Early SOF at the head: leave it for the next origin.
            sof_err <= 1'b1;
            state   <= SEEK;
          end else if (underflow_cnt != 16'hFFFF) begin
            underflow_cnt <= underflow_cnt + 16'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_dvi_stream_timing.sv
// Self-checking bench for dvi_stream_timing with a small 14x7 raster.
// Expected outputs are pushed to a scoreboard queue as each cycle's stimulus is driven
// and popped when the registered outputs appear one clock later.
module tb_dvi_stream_timing;

  localparam int HA    = 8;
  localparam int HT    = 14;
  localparam int VA    = 4;
  localparam int VT    = 7;
  localparam int FRAME = HT * VT;

  localparam int M_IDLE = 0;
  localparam int M_SEEK = 1;
  localparam int M_LOCK = 2;

  typedef struct packed {
    logic        de;
    logic        hs;
    logic        vs;
    logic        fs;
    logic        se;
    logic [23:0] rgb;
    logic [15:0] uf;
  } obs_t;

  logic        clk_dot = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        pix_valid;
  logic        pix_sof;
  logic [23:0] pix_rgb;
  logic        pix_ready;
  logic        vid_de;
  logic        vid_hs;
  logic        vid_vs;
  logic [23:0] vid_rgb;
  logic        frame_start;
  logic        sof_err;
  logic [15:0] underflow_cnt;

  int total = 0;
  int bad   = 0;

  obs_t        exp_q[$];
  logic        rdy_q[$];
  logic [24:0] src_q[$];
  int          gap  = 0;
  int          m_st = M_IDLE;
  int          mh   = 0;
  int          mv   = 0;
  int          m_uf = 0;

  obs_t got;
  obs_t e;
  logic got_rdy;
  logic er;

  dvi_stream_timing #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) dut (
    .clk_dot      (clk_dot),
    .reset_n      (reset_n),
    .enable       (enable),
    .pix_valid    (pix_valid),
    .pix_sof      (pix_sof),
    .pix_rgb      (pix_rgb),
    .pix_ready    (pix_ready),
    .vid_de       (vid_de),
    .vid_hs       (vid_hs),
    .vid_vs       (vid_vs),
    .vid_rgb      (vid_rgb),
    .frame_start  (frame_start),
    .sof_err      (sof_err),
    .underflow_cnt(underflow_cnt)
  );

  always #5 clk_dot = ~clk_dot;

`ifdef DVI_STREAM_TIMING_TEST_PATTERN_EN
  // Bar width is 8/8 = 1 pixel, so bar k covers h == k.
  function automatic logic [23:0] bar_px(input int h);
    case (h)
      0:       return 24'hFFFFFF;
      1:       return 24'hFFFF00;
      2:       return 24'h00FFFF;
      3:       return 24'h00FF00;
      4:       return 24'hFF00FF;
      5:       return 24'hFF0000;
      6:       return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction
`endif

  // One dot clock: present the stream head (or a gap), push expectations, clock, sample.
  task automatic cycle();
    obs_t        x;
    logic        rdy;
    logic        act;
    logic        org;
    logic        last;
    logic [24:0] dump;
    if (gap > 0) begin
      pix_valid = 1'b0; pix_sof = 1'b0; pix_rgb = 24'h5A5A5A; gap--;
    end else if (src_q.size() > 0) begin
      pix_valid = 1'b1; pix_sof = src_q[0][24]; pix_rgb = src_q[0][23:0];
    end else begin
      pix_valid = 1'b0; pix_sof = 1'b0; pix_rgb = 24'hA5A5A5;
    end
    act  = (mh < HA) && (mv < VA);
    org  = (mh == 0) && (mv == 0);
    last = (mh == HT - 1) && (mv == VT - 1);
    rdy  = 1'b0;
    if (m_st == M_SEEK) rdy = !(pix_valid && pix_sof);
    else if (m_st == M_LOCK) rdy = act && !(pix_valid && pix_sof && !org);
    x = '0;
    if (!enable) begin
      m_st = M_IDLE; mh = 0; mv = 0;
    end else if (m_st == M_IDLE) begin
      m_st = M_SEEK;
    end else begin
      x.de = act;
      x.hs = (mh >= 10) && (mh < 12);
      x.vs = (mv == 5);
      x.fs = org;
`ifdef DVI_STREAM_TIMING_TEST_PATTERN_EN
      if (act) x.rgb = bar_px(mh);
`endif
      if (m_st == M_SEEK) begin
        if (last && pix_valid && pix_sof) m_st = M_LOCK;
      end else if (act) begin
        if (pix_valid && rdy) begin
          x.rgb = pix_rgb;
          if (org && !pix_sof) begin x.se = 1'b1; m_st = M_SEEK; end
        end else if (pix_valid) begin
          x.se = 1'b1; m_st = M_SEEK;
        end else if (m_uf < 65535) begin
          m_uf++;
        end
      end
      if (mh == HT - 1) begin
        mh = 0;
        mv = (mv == VT - 1) ? 0 : mv + 1;
      end else begin
        mh++;
      end
    end
    x.uf = 16'(m_uf);
    exp_q.push_back(x);
    rdy_q.push_back(rdy);
    if (pix_valid && rdy) dump = src_q.pop_front();
    #1 got_rdy = pix_ready;
    @(posedge clk_dot);
    #1 got = {vid_de, vid_hs, vid_vs, frame_start, sof_err, vid_rgb, underflow_cnt};
    @(negedge clk_dot);
  endtask

  task automatic test_reset();
    reset_n = 1'b1; enable = 1'b0; pix_valid = 1'b0; pix_sof = 1'b0; pix_rgb = '0;
    #1 reset_n = 1'b0;
    #1;
    total++;
    if ({vid_de, vid_hs, vid_vs, frame_start, sof_err, vid_rgb, underflow_cnt} !== 45'd0) begin
      bad++; $display("FAIL reset_outputs got=%h exp=0", {vid_de, vid_hs, vid_vs, frame_start, sof_err, vid_rgb, underflow_cnt});
    end
    total++;
    if (pix_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", pix_ready); end
    @(negedge clk_dot);
    reset_n = 1'b1;
    repeat (3) begin
      cycle();
      e = exp_q.pop_front(); er = rdy_q.pop_front();
      total++; if (got !== e) begin bad++; $display("FAIL reset_idle out got=%h exp=%h", got, e); end
      total++; if (got_rdy !== er) begin bad++; $display("FAIL reset_idle ready got=%b exp=%b", got_rdy, er); end
    end
  endtask

  task automatic test_free_run();
    int fs_at[$];
    int de_n = 0, hs_n = 0, vs_n = 0;
    enable = 1'b1;
    for (int i = 0; i < 200; i++) begin
      cycle();
      e = exp_q.pop_front(); er = rdy_q.pop_front();
      total++; if (got !== e) begin bad++; $display("FAIL free_run out i=%0d got=%h exp=%h", i, got, e); end
      total++; if (got_rdy !== er) begin bad++; $display("FAIL free_run ready i=%0d got=%b exp=%b", i, got_rdy, er); end
      if (got.fs) fs_at.push_back(i);
      if (got.de) de_n++;
      if (got.hs) hs_n++;
      if (got.vs) vs_n++;
    end
    total++;
    if (fs_at.size() != 3) begin bad++; $display("FAIL free_run fs_count got=%0d exp=3", fs_at.size()); end
    else begin
      total++;
      if (fs_at[0] != 1 || fs_at[1] - fs_at[0] != 98 || fs_at[2] - fs_at[1] != 98) begin
        bad++; $display("FAIL free_run fs_spacing got=%0d,%0d,%0d exp=1,99,197", fs_at[0], fs_at[1], fs_at[2]);
      end
    end
    total++; if (de_n != 67) begin bad++; $display("FAIL free_run de_count got=%0d exp=67", de_n); end
    total++; if (hs_n != 28) begin bad++; $display("FAIL free_run hs_count got=%0d exp=28", hs_n); end
    total++; if (vs_n != 28) begin bad++; $display("FAIL free_run vs_count got=%0d exp=28", vs_n); end
    total++; if (underflow_cnt !== 16'd0) begin bad++; $display("FAIL free_run underflow got=%0d exp=0", underflow_cnt); end
  endtask

  task automatic test_stream();
    logic [23:0] seen[$];
    int n, se_n = 0;
    for (int i = 0; i < 32; i++) src_q.push_back({(i == 0), 24'(i)});
    n = (FRAME - 1) - (mv * HT + mh) + 1;
    repeat (n) begin
      cycle();
      e = exp_q.pop_front(); er = rdy_q.pop_front();
      total++; if (got !== e) begin bad++; $display("FAIL stream_seek out got=%h exp=%h", got, e); end
      total++; if (got_rdy !== er) begin bad++; $display("FAIL stream_seek ready got=%b exp=%b", got_rdy, er); end
    end
    for (int i = 0; i < FRAME; i++) begin
      cycle();
      e = exp_q.pop_front(); er = rdy_q.pop_front();
      total++; if (got !== e) begin bad++; $display("FAIL stream out i=%0d got=%h exp=%h", i, got, e); end
      total++; if (got_rdy !== er) begin bad++; $display("FAIL stream ready i=%0d got=%b exp=%b", i, got_rdy, er); end
      if (i == 0) begin
        total++;
        if (got.fs !== 1'b1 || got.rgb !== 24'd0) begin
          bad++; $display("FAIL stream first_pixel fs=%b rgb=%h exp fs=1 rgb=0", got.fs, got.rgb);
        end
      end
      if (got.de) seen.push_back(got.rgb);
      if (got.se) se_n++;
    end
    total++;
    if (seen.size() != 32) begin bad++; $display("FAIL stream de_count got=%0d exp=32", seen.size()); end
    else begin
      for (int k = 0; k < 32; k++) begin
        total++;
        if (seen[k] !== 24'(k)) begin bad++; $display("FAIL stream pixel k=%0d got=%h exp=%h", k, seen[k], 24'(k)); end
      end
    end
    total++; if (se_n != 0) begin bad++; $display("FAIL stream sof_err got=%0d exp=0", se_n); end
  endtask

  task automatic test_underflow();
    int se_n = 0;
    for (int i = 0; i < 29; i++) src_q.push_back({(i == 0), 24'(100 + i)});
    for (int i = 0; i < FRAME; i++) begin
      if (i == 3) gap = 3;
      cycle();
      e = exp_q.pop_front(); er = rdy_q.pop_front();
      total++; if (got !== e) begin bad++; $display("FAIL underflow out i=%0d got=%h exp=%h", i, got, e); end
      total++; if (got_rdy !== er) begin bad++; $display("FAIL underflow ready i=%0d got=%b exp=%b", i, got_rdy, er); end
      if (i == 3) begin
        total++;
        if (got.de !== 1'b1 || got.rgb !== 24'd0) begin
          bad++; $display("FAIL underflow fill de=%b rgb=%h exp de=1 rgb=0", got.de, got.rgb);
        end
      end
      if (i == 6) begin
        total++;
        if (got.rgb !== 24'd103) begin bad++; $display("FAIL underflow resume got=%h exp=%h", got.rgb, 24'd103); end
      end
      if (got.se) se_n++;
    end
    total++; if (underflow_cnt !== 16'd3) begin bad++; $display("FAIL underflow count got=%0d exp=3", underflow_cnt); end
    total++; if (se_n != 0) begin bad++; $display("FAIL underflow sof_err got=%0d exp=0", se_n); end
  endtask

  task automatic test_sof_mid();
    int se_n = 0;
    src_q.push_back({1'b1, 24'd200});
    for (int i = 1; i < 5; i++) src_q.push_back({1'b0, 24'(200 + i)});
    for (int i = 0; i < 32; i++) src_q.push_back({(i == 0), 24'(300 + i)});
    for (int i = 0; i < 2 * FRAME; i++) begin
      cycle();
      e = exp_q.pop_front(); er = rdy_q.pop_front();
      total++; if (got !== e) begin bad++; $display("FAIL sof_mid out i=%0d got=%h exp=%h", i, got, e); end
      total++; if (got_rdy !== er) begin bad++; $display("FAIL sof_mid ready i=%0d got=%b exp=%b", i, got_rdy, er); end
      if (i == 5) begin
        total++;
        if (got.se !== 1'b1 || got.de !== 1'b1 || got.rgb !== 24'd0) begin
          bad++; $display("FAIL sof_mid early_sof se=%b de=%b rgb=%h exp se=1 de=1 rgb=0", got.se, got.de, got.rgb);
        end
      end
      if (i == FRAME) begin
        total++;
        if (got.fs !== 1'b1 || got.rgb !== 24'd300) begin
          bad++; $display("FAIL sof_mid relock fs=%b rgb=%h exp fs=1 rgb=%h", got.fs, got.rgb, 24'd300);
        end
      end
      if (i == FRAME + 1) begin
        total++;
        if (got.rgb !== 24'd301) begin bad++; $display("FAIL sof_mid relock_next got=%h exp=%h", got.rgb, 24'd301); end
      end
      if (got.se) se_n++;
    end
    total++; if (se_n != 1) begin bad++; $display("FAIL sof_mid sof_err_count got=%0d exp=1", se_n); end
  endtask

  task automatic test_enable_drop();
    for (int i = 0; i < 29; i++) begin
      enable = !(i >= 5 && i < 9);
      cycle();
      e = exp_q.pop_front(); er = rdy_q.pop_front();
      total++; if (got !== e) begin bad++; $display("FAIL enable out i=%0d got=%h exp=%h", i, got, e); end
      total++; if (got_rdy !== er) begin bad++; $display("FAIL enable ready i=%0d got=%b exp=%b", i, got_rdy, er); end
      if (i == 5) begin
        total++;
        if (got.de !== 1'b0 || got.hs !== 1'b0 || got.vs !== 1'b0) begin
          bad++; $display("FAIL enable drop de=%b hs=%b vs=%b exp 0 0 0", got.de, got.hs, got.vs);
        end
      end
      if (i == 6) begin
        total++; if (got_rdy !== 1'b0) begin bad++; $display("FAIL enable drop_ready got=%b exp=0", got_rdy); end
      end
      if (i == 10) begin
        total++;
        if (got.fs !== 1'b1 || got.de !== 1'b1) begin
          bad++; $display("FAIL enable restart fs=%b de=%b exp fs=1 de=1", got.fs, got.de);
        end
      end
    end
    total++; if (underflow_cnt !== 16'd8) begin bad++; $display("FAIL enable underflow_held got=%0d exp=8", underflow_cnt); end
  endtask

  task automatic test_async_reset();
    total++; if (vid_de !== 1'b1) begin bad++; $display("FAIL areset pre_de got=%b exp=1", vid_de); end
    #2 reset_n = 1'b0;
    #1;
    total++;
    if ({vid_de, vid_hs, vid_vs, frame_start, sof_err, vid_rgb, underflow_cnt} !== 45'd0) begin
      bad++; $display("FAIL areset outputs got=%h exp=0", {vid_de, vid_hs, vid_vs, frame_start, sof_err, vid_rgb, underflow_cnt});
    end
    total++; if (pix_ready !== 1'b0) begin bad++; $display("FAIL areset ready got=%b exp=0", pix_ready); end
    m_st = M_IDLE; mh = 0; mv = 0; m_uf = 0; gap = 0;
    src_q.delete();
    @(negedge clk_dot);
    reset_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      cycle();
      e = exp_q.pop_front(); er = rdy_q.pop_front();
      total++; if (got !== e) begin bad++; $display("FAIL areset after out i=%0d got=%h exp=%h", i, got, e); end
      total++; if (got_rdy !== er) begin bad++; $display("FAIL areset after ready i=%0d got=%b exp=%b", i, got_rdy, er); end
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_stream();
    test_underflow();
    test_sof_mid();
    test_enable_drop();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dvi_stream_timing.md
# dvi_stream_timing

Video timing generator and pixel-stream aligner that sits directly upstream of the DDR DVI pin stage. It produces DE/HSYNC/VSYNC for the 40 MHz dot clock and pulls 24-bit RGB pixels from a valid/ready stream during the active area only. It locks that stream to the frame origin using a start-of-frame marker and substitutes fill pixels on underflow. Its registered outputs feed the pin stage's DDR output registers directly.

## Interface
Parameters:
- H_ACTIVE, 800: active pixels per line
- H_FP, 40: horizontal front porch, in pixels
- H_SYNC, 128: HSYNC width, in pixels
- H_BP, 88: horizontal back porch, in pixels
- V_ACTIVE, 600: active lines per frame
- V_FP, 1: vertical front porch, in lines
- V_SYNC, 4: VSYNC width, in lines
- V_BP, 23: vertical back porch, in lines
- HS_POL, 1: HSYNC active level
- VS_POL, 1: VSYNC active level

Ports:
- clk_dot  in  1  dot clock; the only clock
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  runs timing when high
- pix_valid  in  1  stream beat valid
- pix_sof  in  1  beat is pixel (0,0) of a frame
- pix_rgb  in  24  {R[7:0],G[7:0],B[7:0]}
- pix_ready  out  1  beat accepted when pix_valid & pix_ready
- vid_de  out  1  data enable to pin stage
- vid_hs  out  1  HSYNC, polarity set by HS_POL
- vid_vs  out  1  VSYNC, polarity set by VS_POL
- vid_rgb  out  24  pixel to pin stage
- frame_start  out  1  one-cycle pulse with output pixel (0,0)
- sof_err  out  1  one-cycle pulse on loss of frame alignment
- underflow_cnt  out  16  saturating count of underflowed active pixels

## Operation
Counters:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL defined the same way.
- h_cnt wraps at H_TOTAL-1. v_cnt steps when h_cnt wraps, and wraps at V_TOTAL-1.
- active = (h_cnt < H_ACTIVE) & (v_cnt < V_ACTIVE).
- hs_on for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC). vs_on uses the same rule on v_cnt.
- origin = (h_cnt==0 & v_cnt==0); eof = (h_cnt==H_TOTAL-1 & v_cnt==V_TOTAL-1).

State machine:
- IDLE: counters held at 0, outputs at reset values, pix_ready=0. Moves to SEEK when enable=1.
- SEEK: timing runs; active pixels output as fill.
  - pix_ready = !(pix_valid & pix_sof), so the stream drains up to and holds its SOF beat.
  - Moves to LOCKED at eof when pix_valid & pix_sof.
- LOCKED: pix_ready = active & !(pix_valid & pix_sof & !origin).
  - Accepted beat with pix_sof=0 at origin: pixel displayed, sof_err pulses, state moves to SEEK.
  - SOF beat at head while active and not at origin: beat not taken, fill output, sof_err pulses, state moves to SEEK.
  - active & !pix_valid: underflow. Fill pixel output, underflow_cnt increments (saturates at 16'hFFFF), state stays LOCKED.
- Any state with enable=0: IDLE on the next clock. Counters clear and underflow_cnt is held.
- Fill pixel is 24'h000000 unless the configuration macro is defined.
- pix_ready is combinational from registered state/counters and pix_valid/pix_sof. It never depends on pix_rgb.

## Timing
- vid_* and frame_start are registered: 1 cycle after the counter state (and accepted beat) that produced them.
- Reset values: vid_de=0, vid_hs=!HS_POL, vid_vs=!VS_POL, vid_rgb=0, frame_start=0, sof_err=0, underflow_cnt=0, pix_ready=0, state IDLE, counters 0.
- vid_rgb=0 whenever vid_de=0.
- vid_vs changes only on the cycle following h_cnt==0.
- Reset asserted mid-frame returns everything to reset values immediately. Stream alignment is lost, and SEEK is required after release.
- frame_start pulses in LOCKED and SEEK alike, aligned to the vid_de of pixel (0,0).

## Configuration
- Macro: DVI_STREAM_TIMING_TEST_PATTERN_EN.
- Defined: fill pixels are 8 vertical colour bars, left to right: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
  - Bar width is H_ACTIVE/8 pixels (integer division); leftover pixels stay in the last bar.
  - The bar index comes from a counter that resets at h_cnt==0. No divider.
- Not defined: fill is 24'h000000 and no bar logic is synthesised.

## Test plan
Bench parameters: H_ACTIVE=8, H_FP=2, H_SYNC=2, H_BP=2, V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1, both polarities 1.
- Reset, then enable=1 with no stream -> per line, 8 DE cycles then HS high on h=10..11. VS high on line 5 only. frame_start every 98 cycles. underflow_cnt stays 0 (SEEK).
- Continuous stream starting with SOF, pixel value = index -> LOCKED after the first eof. vid_rgb = 0..31 in DE cycles of the next frame. frame_start coincides with pixel 0. No sof_err.
- In LOCKED, deassert pix_valid for 3 active cycles -> 3 fill pixels output, underflow_cnt=3, still locked, following pixels undelayed.
- In LOCKED, present SOF at active pixel 5 -> beat held, sof_err pulse, SEEK. Relock at the next eof. That SOF pixel is displayed at (0,0).
- Drop enable mid-line -> next cycle vid_de=0, vid_hs=vid_vs=0, pix_ready=0. Re-enable -> counters restart from 0 in SEEK.
- Assert reset_n=0 asynchronously mid-active -> all outputs at reset values without a clock edge. With the macro defined, SEEK fill on vid_rgb is FFFFFF for h=0, FFFF00 for h=1, ..., 000000 for h=7.
